// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage.
// Holds the reset and exception entry addresses, the legal instruction-memory
// window, and the ExcCode values produced by the fetch address check.
package fetch_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [DATA_W-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [DATA_W-1:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [DATA_W-1:0] IM_BASE    = 32'h0000_3000;
  localparam logic [DATA_W-1:0] IM_LAST    = 32'h0000_6FFC;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  // Link value of an instruction: the address after its delay slot.
  function automatic logic [DATA_W-1:0] link_addr(input logic [DATA_W-1:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control/redirect inputs, instruction-memory read data,
// the fetch PC, and the F/D pipeline register contents seen by decode.
// master : the fetch unit (drives pc_F and the *_D outputs, fetch_cnt)
// slave  : the surrounding pipeline (hazard unit, CP0, IM, next-PC calc, decode)
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              stall;
  logic [DATA_W-1:0] npc;
  logic              req;
  logic              eret;
  logic [DATA_W-1:0] epc;
  logic              bd_F;
  logic [DATA_W-1:0] instr_F;
  logic [DATA_W-1:0] pc_F;
  logic [DATA_W-1:0] pc_D;
  logic [DATA_W-1:0] instr_D;
  logic [DATA_W-1:0] pc8_D;
  logic [EXC_W-1:0]  exc_D;
  logic              bd_D;
  logic              valid_D;
  logic [DATA_W-1:0] fetch_cnt;

  modport master (
    input  stall, npc, req, eret, epc, bd_F, instr_F,
    output pc_F, pc_D, instr_D, pc8_D, exc_D, bd_D, valid_D, fetch_cnt
  );

  modport slave (
    output stall, npc, req, eret, epc, bd_F, instr_F,
    input  pc_F, pc_D, instr_D, pc8_D, exc_D, bd_D, valid_D, fetch_cnt
  );

endinterface

// File: rtl/fetch_unit_addr_check.sv
// fetch_addr_check: combinational legality check of an instruction address.
// Ports:
//   pc       in  32  address to check
//   bad      out 1   address misaligned or outside [IM_BASE, IM_LAST]
//   exc_code out 5   EXC_ADEL when bad, EXC_NONE otherwise
// Written generically so the D-side data-address check can reuse it.
module fetch_addr_check
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_W-1:0] IM_BASE_P  = IM_BASE,
  parameter logic [DATA_W-1:0] IM_LAST_P  = IM_LAST,
  parameter logic [EXC_W-1:0]  EXC_ADEL_P = EXC_ADEL
) (
  input  logic [DATA_W-1:0] pc,
  output logic              bad,
  output logic [EXC_W-1:0]  exc_code
);

  always_comb begin
    bad      = (pc[1:0] != 2'b00) || (pc < IM_BASE_P) || (pc > IM_LAST_P);
    exc_code = bad ? EXC_ADEL_P : EXC_NONE;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: F stage of the five-stage MIPS pipeline.
// Holds the fetch PC, follows npc each cycle, redirects to the exception
// handler (req) or to EPC (eret), and fills the F/D register for decode.
// Ports:
//   clk    in  1   system clock, rising edge
//   reset  in  1   synchronous active-high reset
//   bus    fetch_unit_if.master
//          in : stall, npc, req, eret, epc, bd_F, instr_F
//          out: pc_F, pc_D, instr_D, pc8_D, exc_D, bd_D, valid_D, fetch_cnt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC_P   = RESET_PC,
  parameter logic [DATA_W-1:0] HANDLER_PC_P = HANDLER_PC,
  parameter logic [DATA_W-1:0] IM_BASE_P    = IM_BASE,
  parameter logic [DATA_W-1:0] IM_LAST_P    = IM_LAST,
  parameter logic [EXC_W-1:0]  EXC_ADEL_P   = EXC_ADEL
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [DATA_W-1:0] pc_f_q, pc_f_d;
  logic [DATA_W-1:0] pc_d_q, pc_d_d;
  logic [DATA_W-1:0] instr_d_q, instr_d_d;
  logic [DATA_W-1:0] pc8_d_q, pc8_d_d;
  logic [EXC_W-1:0]  exc_d_q, exc_d_d;
  logic              bd_d_q, bd_d_d;
  logic              valid_d_q, valid_d_d;
  logic [DATA_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic              fetch_bad;
  logic [EXC_W-1:0]  fetch_exc;

  fetch_addr_check #(
    .IM_BASE_P  (IM_BASE_P),
    .IM_LAST_P  (IM_LAST_P),
    .EXC_ADEL_P (EXC_ADEL_P)
  ) u_addr_check (
    .pc       (pc_f_q),
    .bad      (fetch_bad),
    .exc_code (fetch_exc)
  );

  always_comb begin
    pc_f_d      = pc_f_q;
    pc_d_d      = pc_d_q;
    instr_d_d   = instr_d_q;
    pc8_d_d     = pc8_d_q;
    exc_d_d     = exc_d_q;
    bd_d_d      = bd_d_q;
    valid_d_d   = valid_d_q;
    fetch_cnt_d = fetch_cnt_q;

    if (bus.req || bus.eret) begin
      // Redirects override stall; the instruction in F is discarded and D
      // becomes a bubble (eret has no delay slot to keep).
      pc_f_d    = bus.req ? HANDLER_PC_P : bus.epc;
      pc_d_d    = '0;
      instr_d_d = '0;
      pc8_d_d   = '0;
      exc_d_d   = EXC_NONE;
      bd_d_d    = 1'b0;
      valid_d_d = 1'b0;
    end else if (!bus.stall) begin
      pc_f_d      = bus.npc;
      pc_d_d      = pc_f_q;
      pc8_d_d     = link_addr(pc_f_q);
      bd_d_d      = bus.bd_F;
      valid_d_d   = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      // A bad fetch still advances with its PC so CP0 can record it, but
      // carries a nop instead of whatever IM returned.
      exc_d_d     = fetch_exc;
      instr_d_d   = fetch_bad ? '0 : bus.instr_F;
    end
  end

  // F/D register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= RESET_PC_P;
      pc_d_q      <= '0;
      instr_d_q   <= '0;
      pc8_d_q     <= '0;
      exc_d_q     <= EXC_NONE;
      bd_d_q      <= 1'b0;
      valid_d_q   <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_f_q      <= pc_f_d;
      pc_d_q      <= pc_d_d;
      instr_d_q   <= instr_d_d;
      pc8_d_q     <= pc8_d_d;
      exc_d_q     <= exc_d_d;
      bd_d_q      <= bd_d_d;
      valid_d_q   <= valid_d_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.pc_F      = pc_f_q;
  assign bus.pc_D      = pc_d_q;
  assign bus.instr_D   = instr_d_q;
  assign bus.pc8_D     = pc8_d_q;
  assign bus.exc_D     = exc_d_q;
  assign bus.bd_D      = bd_d_q;
  assign bus.valid_D   = valid_d_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the F stage.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic [31:0] m_pcF, m_pcD, m_instrD, m_pc8D, m_cnt;
  logic [4:0]  m_excD;
  logic        m_bdD, m_vD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  // Next model state from the inputs present before the edge.
  task automatic model_step();
    if (reset) begin
      m_pcF = 32'h3000; m_pcD = 0; m_instrD = 0; m_pc8D = 0;
      m_excD = 0; m_bdD = 0; m_vD = 0; m_cnt = 0;
    end else if (bus.req || bus.eret) begin
      m_pcF = bus.req ? 32'h4180 : bus.epc;
      m_pcD = 0; m_instrD = 0; m_pc8D = 0; m_excD = 0; m_bdD = 0; m_vD = 0;
    end else if (!bus.stall) begin
      m_pcD    = m_pcF;
      m_pc8D   = m_pcF + 8;
      m_bdD    = bus.bd_F;
      m_vD     = 1;
      m_cnt    = m_cnt + 1;
      m_excD   = addr_bad(m_pcF) ? 5'd4 : 5'd0;
      m_instrD = addr_bad(m_pcF) ? 32'h0 : bus.instr_F;
      m_pcF    = bus.npc;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_F"},      bus.pc_F,            m_pcF);
    check({tag, ".pc_D"},      bus.pc_D,            m_pcD);
    check({tag, ".instr_D"},   bus.instr_D,         m_instrD);
    check({tag, ".pc8_D"},     bus.pc8_D,           m_pc8D);
    check({tag, ".exc_D"},     {27'd0, bus.exc_D},  {27'd0, m_excD});
    check({tag, ".bd_D"},      {31'd0, bus.bd_D},   {31'd0, m_bdD});
    check({tag, ".valid_D"},   {31'd0, bus.valid_D},{31'd0, m_vD});
    check({tag, ".fetch_cnt"}, bus.fetch_cnt,       m_cnt);
  endtask

  // One clock: update model, take the edge, compare #1 later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    reset = 0; bus.stall = 0; bus.req = 0; bus.eret = 0;
    bus.epc = 0; bus.bd_F = 0;
  endtask

  initial begin
    m_pcF = 0; m_pcD = 0; m_instrD = 0; m_pc8D = 0; m_excD = 0;
    m_bdD = 0; m_vD = 0; m_cnt = 0;
    idle_inputs();
    bus.npc = 0; bus.instr_F = 0;
    reset = 1;
    @(negedge clk);
    cycle("reset");
    check("reset_pc_const", bus.pc_F, 32'h3000);
    check("reset_valid_const", {31'd0, bus.valid_D}, 32'd0);
    reset = 0;

    // Sequential fetch
    bus.instr_F = 32'h2401_0001;
    bus.npc = m_pcF + 4;
    cycle("seq0");
    check("seq0_pcF_const", bus.pc_F, 32'h3004);
    check("seq0_pcD_const", bus.pc_D, 32'h3000);
    check("seq0_instr_const", bus.instr_D, 32'h2401_0001);
    check("seq0_pc8_const", bus.pc8_D, 32'h3008);
    check("seq0_cnt_const", bus.fetch_cnt, 32'd1);
    bus.npc = m_pcF + 4;
    cycle("seq1");
    check("seq1_pcF_const", bus.pc_F, 32'h3008);

    // Delay slot from 0x300C
    bus.npc = m_pcF + 4;
    cycle("seq2");
    bus.bd_F = 1; bus.npc = m_pcF + 4;
    cycle("bd");
    check("bd_bdD_const", {31'd0, bus.bd_D}, 32'd1);
    check("bd_pcD_const", bus.pc_D, 32'h300C);
    bus.bd_F = 0;

    // Stall for 3 cycles at 0x3010
    bus.stall = 1; bus.npc = 32'h3100;
    for (int i = 0; i < 3; i++) cycle("stall");
    check("stall_pcF_const", bus.pc_F, 32'h3010);
    check("stall_cnt_const", bus.fetch_cnt, 32'd4);
    bus.stall = 0; bus.npc = 32'h3014;
    cycle("stall_rel");
    check("stall_rel_cnt_const", bus.fetch_cnt, 32'd5);
    bus.npc = 32'h3020;
    cycle("to3020");

    // req wins over stall, and over eret
    bus.req = 1; bus.stall = 1;
    cycle("req_stall");
    check("req_pcF_const", bus.pc_F, 32'h4180);
    bus.stall = 0; bus.eret = 1; bus.epc = 32'h3044;
    cycle("req_eret");
    check("req_eret_pcF_const", bus.pc_F, 32'h4180);
    bus.req = 0;
    cycle("eret");
    check("eret_pcF_const", bus.pc_F, 32'h3044);
    bus.eret = 0; bus.npc = 32'h3002;
    cycle("after_eret");
    check("after_eret_pcD_const", bus.pc_D, 32'h3044);

    // Address errors and the IM_LAST boundary
    bus.npc = 32'h7000;
    cycle("mis");
    check("mis_exc_const", {27'd0, bus.exc_D}, 32'd4);
    bus.npc = 32'h6FFC;
    cycle("oor");
    check("oor_pcD_const", bus.pc_D, 32'h7000);
    bus.npc = 32'h7000;
    cycle("last");
    check("last_exc_const", {27'd0, bus.exc_D}, 32'd0);
    check("last_pcD_const", bus.pc_D, 32'h6FFC);
    cycle("last4");

    // Reset in the middle of a stall
    bus.stall = 1;
    cycle("pre_rst");
    reset = 1;
    cycle("rst_stall");
    check("rst_stall_pc_const", bus.pc_F, 32'h3000);
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.req   = ($urandom_range(0, 29) == 0);
      bus.eret  = ($urandom_range(0, 19) == 0);
      bus.bd_F  = $urandom_range(0, 1) == 1;
      bus.instr_F = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6)       bus.npc = m_pcF + 4;
      else if (r < 8)  bus.npc = 32'h3000 + ($urandom_range(0, 32'h1000) << 2);
      else if (r == 8) bus.npc = 32'h3000 + $urandom_range(0, 32'h4004);
      else             bus.npc = $urandom;
      bus.epc = ($urandom_range(0, 3) == 0) ? $urandom
                                            : 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- F stage of the five-stage MIPS pipeline. Holds the architectural fetch PC and drives it to instruction memory and to the next-PC calculator.
- Latches the next-PC calculator's npc every cycle, with redirects for exception entry and eret, plus stall and flush control.
- Produces the F/D pipeline register (pc, instr, pc+8, exception code, delay-slot flag, valid) consumed by decode.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_LAST, 32'h0000_6FFC, highest legal fetch address (inclusive)
- EXC_ADEL, 5'd4, ExcCode for an address error on fetch

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; freezes pc_F and all D-stage registers
- npc  in  32  next PC from the next-PC calculator
- req  in  1  exception/interrupt taken by CP0 this cycle
- eret  in  1  eret committing this cycle
- epc  in  32  CP0 EPC value, used when eret=1
- bd_F  in  1  instruction now in D is a branch/jump, so the F instruction is a delay slot
- instr_F  in  32  instruction-memory read data for pc_F (combinational read)
- pc_F  out  32  current fetch PC
- pc_D  out  32  PC of the instruction in D
- instr_D  out  32  instruction in D
- pc8_D  out  32  pc_D + 8 (link value)
- exc_D  out  5  fetch exception code of the D instruction; 0 = none
- bd_D  out  1  D instruction is a delay slot
- valid_D  out  1  D holds a real fetched instruction, not a bubble
- fetch_cnt  out  32  count of instructions advanced into D

Behaviour:
- Reset values:
  - pc_F = RESET_PC.
  - pc_D = 0, instr_D = 0, pc8_D = 0, exc_D = 0, bd_D = 0, valid_D = 0, fetch_cnt = 0.
- Per-edge priority: reset > req > eret > stall > advance.
- req=1:
  - pc_F <= HANDLER_PC.
  - D flushed to a bubble: instr_D = 0, exc_D = 0, bd_D = 0, valid_D = 0, pc_D = 0, pc8_D = 0.
  - stall is ignored.
- eret=1 and req=0:
  - pc_F <= epc.
  - D flushed to a bubble as above. eret has no delay slot.
  - stall is ignored.
- stall=1 with no redirect: pc_F, every D register, and fetch_cnt all hold.
- Advance: pc_F <= npc. The D registers load the F values:
  - pc_D <= pc_F.
  - pc8_D <= pc_F + 32'd8, modulo 2^32.
  - bd_D <= bd_F.
  - valid_D <= 1.
  - fetch_cnt increments by 1 and wraps 0xFFFF_FFFF -> 0.
- Fetch address check (combinational on pc_F):
  - The fetch is bad when pc_F[1:0] != 0, or pc_F < IM_BASE, or pc_F > IM_LAST.
  - Bad fetch on advance: exc_D <= EXC_ADEL and instr_D <= 0, so a nop propagates. pc_D still carries the bad pc_F so CP0 can record EPC/BadVAddr. valid_D = 1.
  - Good fetch on advance: exc_D <= 0 and instr_D <= instr_F.
- Boundaries:
  - pc_F = IM_LAST is legal.
  - pc_F = IM_LAST+4 raises AdEL.
  - An epc value that is misaligned or out of range is loaded as-is; the AdEL is raised on the following advance.
- The block does not add 4 itself; sequencing comes entirely from npc.
- pc_F is a registered output with zero-cycle visibility to IM and the next-PC calculator.
- Latency: the instruction at pc_F appears in D one edge later, if not stalled or flushed.

Decomposition:
- Shared package (the constants header already used by the CPU): RESET_PC, HANDLER_PC, IM_BASE, IM_LAST, and ExcCode constants EXC_ADEL, EXC_NONE.
- One sub-module is natural: fetch_addr_check, a combinational pc -> {bad, exccode} block that the D-side data-address check can also reuse.
- The F/D register stays inline.

Test Plan:
- Reset, then release, with npc = pc_F+4 and instr_F = 0x24010001 -> pc_F sequence 0x3000, 0x3004, 0x3008. One edge later pc_D = 0x3000, instr_D = 0x24010001, pc8_D = 0x3008, valid_D = 1, fetch_cnt = 1.
- stall=1 for 3 cycles at pc_F = 0x3010 -> pc_F, pc_D, instr_D and fetch_cnt unchanged. After release, pc_F = npc and fetch_cnt increments once.
- req=1 together with stall=1 at pc_F = 0x3020 -> next pc_F = 0x4180, valid_D = 0, instr_D = 0. req with eret simultaneously -> 0x4180 wins.
- eret=1, epc = 0x3044 -> pc_F = 0x3044 and D is a bubble. Next advance has pc_D = 0x3044, exc_D = 0.
- npc = 0x3002, then 0x7000 -> D shows exc_D = 4, instr_D = 0, pc_D = 0x3002 (then 0x7000). npc = 0x6FFC -> exc_D = 0.
- bd_F=1 on an advance from pc_F = 0x300C -> bd_D = 1 with pc_D = 0x300C. Reset asserted mid-stall -> all outputs return to their reset values on the next edge.
